// File: rtl/alu_seq_pkg.sv
// Shared ALU operation codes (the ALU_control output encoding) and small
// decode helpers used by the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_BGE  = 4'd10;
    localparam logic [3:0] OP_BGEU = 4'd11;
    localparam logic [3:0] OP_EEE  = 4'd15;

    // True for the three shift operations, which take the shifter path.
    function automatic logic is_shift_op(input logic [3:0] func);
        return (func == OP_SLL) || (func == OP_SRL) || (func == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Shift datapath for alu_seq.
// Default build: iterative shifter, one bit per step; a zero amount completes
// at load time with the operand unchanged.
// ALU_SEQ_FAST_SHIFT_EN defined: full combinational barrel shift completed at
// load time; the step/last outputs are tied off.
module alu_seq_shifter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic                          step_i,
    input  logic                          dir_left_i,
    input  logic                          arith_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic [$clog2(DATA_WIDTH)-1:0] amount_i,
    output logic [DATA_WIDTH-1:0]         imm_o,
    output logic                          imm_done_o,
    output logic [DATA_WIDTH-1:0]         step_data_o,
    output logic                          last_o
);

`ifdef ALU_SEQ_FAST_SHIFT_EN

    // Whole shift in one pass; the result is always available at load.
    always_comb begin
        imm_o       = '0;
        imm_done_o  = 1'b1;
        step_data_o = '0;
        last_o      = 1'b0;
        if (dir_left_i) begin
            imm_o = data_i << amount_i;
        end else if (arith_i) begin
            imm_o = $unsigned($signed(data_i) >>> amount_i);
        end else begin
            imm_o = data_i >> amount_i;
        end
    end

`else

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [SHAMT_W-1:0]    count_q, count_d;
    logic                  left_q,  left_d;
    logic                  arith_q, arith_d;

    // One-bit shift of the working value plus completion decode.
    always_comb begin
        imm_o      = data_i;
        imm_done_o = (amount_i == '0);
        last_o     = (count_q == {{(SHAMT_W-1){1'b0}}, 1'b1});
        if (left_q) begin
            step_data_o = {data_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            step_data_o = {arith_q & data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]};
        end
    end

    // Next working value: load a new operand or advance one bit.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (load_i) begin
            data_d  = data_i;
            count_d = amount_i;
            left_d  = dir_left_i;
            arith_d = arith_i;
        end else if (step_i) begin
            data_d  = step_data_o;
            count_d = count_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
        end else begin
            data_d  = data_q;
            count_d = count_q;
        end
    end

    // Working value, remaining count and direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

`endif

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle
// arithmetic/logic/compare ops; shifts go through alu_seq_shifter
// (iterative by default, single-cycle when ALU_SEQ_FAST_SHIFT_EN is defined).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_func,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                state_q,   state_d;
    logic [DATA_WIDTH-1:0] result_q,  result_d;
    logic                  zero_q,    zero_d;
    logic                  illegal_q, illegal_d;

    logic                  in_ready_s;
    logic                  accept_s;
    logic                  load_s;
    logic                  step_s;
    logic [DATA_WIDTH-1:0] alu_res_s;
    logic                  alu_legal_s;
    logic [DATA_WIDTH-1:0] imm_s;
    logic                  imm_done_s;
    logic [DATA_WIDTH-1:0] step_data_s;
    logic                  last_s;

    assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign in_ready   = in_ready_s;
    assign out_valid  = (state_q == ST_DONE);
    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal    = illegal_q;

    alu_seq_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_s),
        .step_i      (step_s),
        .dir_left_i  (alu_func == OP_SLL),
        .arith_i     (alu_func == OP_SRA),
        .data_i      (in_a),
        .amount_i    (in_b[$clog2(DATA_WIDTH)-1:0]),
        .imm_o       (imm_s),
        .imm_done_o  (imm_done_s),
        .step_data_o (step_data_s),
        .last_o      (last_s)
    );

    // Single-cycle arithmetic, logic and compare results; shifts and unknown codes flag not-legal here.
    always_comb begin
        alu_res_s   = '0;
        alu_legal_s = 1'b1;
        case (alu_func)
            OP_ADD:  alu_res_s = in_a + in_b;
            OP_SUB:  alu_res_s = in_a - in_b;
            OP_XOR:  alu_res_s = in_a ^ in_b;
            OP_OR:   alu_res_s = in_a | in_b;
            OP_AND:  alu_res_s = in_a & in_b;
            OP_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_a) <  $signed(in_b))};
            OP_SLTU: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (in_a <  in_b)};
            OP_BGE:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_a) >= $signed(in_b))};
            OP_BGEU: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (in_a >= in_b)};
            default: begin
                alu_res_s   = '0;
                alu_legal_s = 1'b0;
            end
        endcase
    end

    // Next state and result capture; outputs only change when a result completes.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        load_s    = 1'b0;
        step_s    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (is_shift_op(alu_func)) begin
                        load_s = 1'b1;
                        if (imm_done_s) begin
                            result_d  = imm_s;
                            zero_d    = (imm_s == '0);
                            illegal_d = 1'b0;
                            state_d   = ST_DONE;
                        end else begin
                            state_d   = ST_SHIFT;
                        end
                    end else if (alu_legal_s) begin
                        result_d  = alu_res_s;
                        zero_d    = (alu_res_s == '0);
                        illegal_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        result_d  = '0;
                        zero_d    = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SHIFT: begin
                step_s = 1'b1;
                if (last_s) begin
                    result_d  = step_data_s;
                    zero_d    = (step_data_s == '0);
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (DATA_WIDTH = 32).
// Expected shift latencies follow ALU_SEQ_FAST_SHIFT_EN when it is defined.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_func;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_func  (alu_func),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int shift_lat(input int amt);
`ifdef ALU_SEQ_FAST_SHIFT_EN
        return 1;
`else
        return amt + 1;
`endif
    endfunction

    // Issue one op with out_ready high, wait for the result and check it.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input logic exp_ill);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_func  = f;
        in_a      = a;
        in_b      = b;
        #1;
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 80) begin
            check_eq({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_result"}, 64'(result), 64'(exp_res));
        check_eq({tag, "_zero"}, 64'(zero), 64'(exp_res == 32'd0));
        check_eq({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
        tick();
        check_eq({tag, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int rises;
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_func  = OP_ADD;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_zero", 64'(zero), 64'd0);
        check_eq("rst_illegal", 64'(illegal), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // Single-cycle ops, compares and illegal codes.
        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0);
        run_op("sub_neg", OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("or", OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1, 1'b0);
        run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 1'b0);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0);
        run_op("bgeu", OP_BGEU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 1'b0);
        run_op("bge", OP_BGE, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0);
        run_op("bge_eq", OP_BGE, 32'h0000_0007, 32'h0000_0007, 32'h0000_0001, 1, 1'b0);
        run_op("eee", OP_EEE, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1, 1'b1);
        run_op("code12", 4'd12, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1, 1'b1);

        // Shifts: amount taken from in_b[4:0] only.
        run_op("sra", OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, shift_lat(4), 1'b0);
        run_op("sra_pos", OP_SRA, 32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF, shift_lat(4), 1'b0);
        run_op("srl", OP_SRL, 32'h8000_0000, 32'h0000_0003, 32'h1000_0000, shift_lat(3), 1'b0);
        run_op("sll_max", OP_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, shift_lat(31), 1'b0);
        run_op("srl_zero_amt", OP_SRL, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1, 1'b0);

        // Back-to-back SUB then XOR.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_func  = OP_SUB;
        in_a      = 32'd5;
        in_b      = 32'd3;
        #1;
        check_eq("b2b_ready0", 64'(in_ready), 64'd1);
        tick();
        check_eq("b2b_valid1", 64'(out_valid), 64'd1);
        check_eq("b2b_res1", 64'(result), 64'd2);
        alu_func = OP_XOR;
        in_a     = 32'd6;
        in_b     = 32'd6;
        #1;
        check_eq("b2b_ready1", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_eq("b2b_valid2", 64'(out_valid), 64'd1);
        check_eq("b2b_res2", 64'(result), 64'd0);
        check_eq("b2b_zero2", 64'(zero), 64'd1);
        tick();
        check_eq("b2b_idle", 64'(out_valid), 64'd0);

        // Backpressure: result held for three cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_func  = OP_AND;
        in_a      = 32'h0000_00F0;
        in_b      = 32'h0000_003C;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_result", 64'(result), 64'h30);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 64'(in_ready), 64'd1);
        check_eq("bp_release_result", 64'(result), 64'h30);
        tick();
        check_eq("bp_idle", 64'(out_valid), 64'd0);

        // Reset has priority over an accept in the same cycle.
        rst      = 1'b1;
        in_valid = 1'b1;
        alu_func = OP_ADD;
        in_a     = 32'd2;
        in_b     = 32'd2;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check_eq("rst_prio_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of a long shift.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_func  = OP_SLL;
        in_a      = 32'd1;
        in_b      = 32'd20;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("mid_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_result", 64'(result), 64'd0);
        rises = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) rises++;
        end
        check_eq("mid_rst_no_output", 64'(rises), 64'd0);
        run_op("add_after_rst", OP_ADD, 32'd2, 32'd2, 32'd4, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port alu_func  input  4  operation code from the shared OP_* define set (the ALU_control output encoding).
REQ-007 SHALL have port in_a  input  DATA_WIDTH  operand A (rs1).
REQ-008 SHALL have port in_b  input  DATA_WIDTH  operand B (rs2 or immediate).
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  DATA_WIDTH  operation result.
REQ-012 SHALL have port zero  output  1  result equals 0.
REQ-013 SHALL have port illegal  output  1  accepted code was OP_EEE or unlisted; qualified by out_valid.

Function
REQ-014 SHALL accept a request when in_valid && in_ready, capturing alu_func, in_a, in_b.
REQ-015 SHALL implement FSM IDLE, SHIFT, DONE; IDLE->DONE on accept of non-shift op or shift amount 0; IDLE->SHIFT on accept of SLL/SRL/SRA with amount >0; SHIFT->DONE when remaining count reaches 0; DONE->IDLE on out_ready without new accept.
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); accept in DONE with out_ready goes directly to DONE or SHIFT (back-to-back, one op/cycle for non-shift ops).
REQ-017 SHALL compute ADD, SUB (two's complement, wrap modulo 2^DATA_WIDTH, no carry out), XOR, OR, AND in one cycle: accept at cycle N, out_valid at N+1.
REQ-018 SHALL set result for SLT/SLTU to 1 if A<B signed/unsigned else 0; BGE/BGEU to 1 if A>=B signed/unsigned else 0; one-cycle latency.
REQ-019 SHALL use shift amount = in_b[log2(DATA_WIDTH)-1:0]; upper bits of in_b ignored.
REQ-020 SHALL perform iterative shifts one bit per cycle in SHIFT: SLL zero-fill, SRL zero-fill, SRA sign-fill; latency = amount+1 cycles (amount 0 -> 1 cycle, result = A).
REQ-021 SHALL hold result, zero, illegal stable while out_valid && !out_ready.
REQ-022 SHALL on illegal code set result 0, zero 1, illegal 1, latency 1.
REQ-023 SHALL keep in_ready 0 throughout SHIFT; in_valid ignored there.
REQ-024 SHALL assert out_valid only in DONE.

Reset
REQ-025 SHALL on rst force state IDLE, out_valid 0, result 0, zero 0, illegal 0, shift count 0; in_ready 1 the cycle after.
REQ-026 SHALL abandon any in-flight operation (SHIFT or DONE) on rst with no output produced; rst has priority over accept in the same cycle.

Configuration
REQ-027 SHALL honour macro ALU_SEQ_FAST_SHIFT_EN: defined -> shifts computed combinationally with one-cycle latency like REQ-017, SHIFT state unused; undefined -> iterative per REQ-020.

Structure
REQ-028 SHALL take OP_* codes from the shared defines header (no local redefinition); FSM state encoding local to the module.
REQ-029 SHALL place shift datapath in sub-module alu_seq_shifter (load, step, direction, arith-fill, done), replaced by combinational shifter under ALU_SEQ_FAST_SHIFT_EN.

Verification
REQ-030 SHALL cover ADD A=0xFFFFFFFF, B=1 -> result 0x0, zero 1, out_valid cycle N+1.
REQ-031 SHALL cover SRA A=0x80000000, B=0x24 (amount 4) -> result 0xF8000000 after 5 cycles; in_ready 0 during SHIFT (1 cycle if ALU_SEQ_FAST_SHIFT_EN).
REQ-032 SHALL cover SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0; BGEU same -> 1.
REQ-033 SHALL cover back-to-back SUB 5-3 then XOR 6^6 with out_ready=1 -> results 2 then 0 on consecutive cycles, in_ready never low.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles after AND 0xF0&0x3C -> result 0x30 held, in_ready 0, then released.
REQ-035 SHALL cover rst asserted mid-SHIFT (SLL amount 20, cycle 5) -> out_valid never rises, state IDLE, next ADD 2+2 -> 4.
